alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Command front-end for the 4-bit ALU. It buffers operand/opcode commands from a producer in a small FIFO and issues them one at a time to the ALU with a single-cycle start pulse. It waits for the ALU's done, captures the result and error, and presents them to a consumer over a valid/ready response port. It sits directly upstream of the ALU, drives its A/B/opcode/start inputs, and consumes its Result/Done/Error outputs.

Parameters:
DEPTH, 4, command FIFO entries; power of two, at least 2
TIMEOUT, 15, maximum cycles in WAIT before a timeout response; at least 2

Ports:
clk  in  1  single clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  producer command valid
cmd_ready  out  1  FIFO can accept (= not full)
cmd_a  in  4  operand A
cmd_b  in  4  operand B
cmd_op  in  2  00 add, 01 sub, 10 mul, 11 div
alu_A  out  4  to ALU A
alu_B  out  4  to ALU B
alu_opcode  out  2  to ALU opcode
alu_start  out  1  to ALU start; one-cycle pulse
alu_result  in  8  from ALU Result
alu_done  in  1  from ALU Done
alu_error  in  1  from ALU Error
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_result  out  8  captured result
rsp_error  out  1  captured ALU error (divide by zero)
rsp_timeout  out  1  ALU never signalled done
busy  out  1  FSM not in IDLE
cmd_count  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, active-high) values:
  - All outputs 0: cmd_ready=1 since the FIFO is empty.
  - FIFO pointers and count cleared; FSM to IDLE; timeout counter 0.
- Reset mid-operation: abandons the in-flight command and all queued commands; no response is produced.
- Command push:
  - Occurs on the edge where cmd_valid && cmd_ready.
  - cmd_ready = (cmd_count != DEPTH). There is no full-bypass: a push while full is refused even if a pop happens in the same cycle.
  - Simultaneous push and pop leave cmd_count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, HOLD. All outputs are registered.
  - IDLE: if FIFO non-empty, load alu_A/alu_B/alu_opcode from the head entry, pop, assert alu_start, go to ISSUE. Otherwise stay.
  - ISSUE: one cycle with alu_start=1. Next edge: alu_start=0, clear counter, go to WAIT.
  - WAIT:
    - alu_done=1: capture rsp_result=alu_result, rsp_error=alu_error, rsp_timeout=0, set rsp_valid, go to HOLD.
    - Otherwise increment counter. When counter reaches TIMEOUT-1 without done: rsp_result=0, rsp_error=0, rsp_timeout=1, set rsp_valid, go to HOLD.
  - HOLD: rsp_valid and the rsp_* values are held stable until rsp_ready=1. On that edge rsp_valid=0 and go to IDLE.
- alu_done in IDLE, ISSUE or HOLD is ignored. ALU Done is one cycle late relative to start, so a stale done is never sampled as a new result.
- alu_A/alu_B/alu_opcode stay stable from ISSUE through exit from WAIT, and hold their last values otherwise.
- Latency with the FIFO empty and FSM in IDLE, push at edge N:
  - IDLE→ISSUE at N+1, so alu_start is high in cycle N+1..N+2.
  - ALU samples start at N+2 and Done is high after N+2.
  - Done is captured at N+3, so rsp_valid is high after N+3.
  - Response throughput is 1 per 4 cycles with rsp_ready tied high.
- Only one command is in flight. Total capacity is DEPTH queued plus 1 in flight.
- busy = (state != IDLE).
- Responses are in command order. No reordering, no dropping except on reset.
- Width rules: rsp_result is the 8-bit ALU result unmodified. Subtraction underflow appears as an 8-bit two's-complement wrap, e.g. 3-5 = 0xFE.

Test Plan:
- Reset, then push {A=7,B=9,op=00} with rsp_ready=1 -> alu_start high exactly one cycle; rsp_valid 3 cycles after push edge; rsp_result=0x10, rsp_error=0, rsp_timeout=0.
- Push sub 3-5, mul 15*15, div 9/2 back-to-back -> responses in order: 0xFE, 0xE1, 0x04; each alu_start a single pulse; operands stable while in WAIT.
- Push {A=6,B=0,op=11} -> rsp_result=0x00, rsp_error=1.
- Hold rsp_ready=0 and push DEPTH+2 commands -> first command in HOLD, next DEPTH accepted, cmd_ready=0 with cmd_count=DEPTH; one push refused. Raise rsp_ready -> all DEPTH+1 accepted commands drain in order.
- Tie alu_done=0 and push one command -> rsp_valid with rsp_timeout=1, rsp_result=0 after TIMEOUT cycles in WAIT. The FSM then proceeds to the next command normally.
- Assert reset while in WAIT with 2 commands queued -> all outputs 0, cmd_count=0, no response after reset release. A new command then completes normally.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the 4-bit ALU: queues operand/opcode commands, issues one at a
// time with a start pulse, and returns the result (or a timeout) over a valid/ready port.
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_a,
  input  logic [3:0]              cmd_b,
  input  logic [1:0]              cmd_op,
  output logic [3:0]              alu_A,
  output logic [3:0]              alu_B,
  output logic [1:0]              alu_opcode,
  output logic                    alu_start,
  input  logic [7:0]              alu_result,
  input  logic                    alu_done,
  input  logic                    alu_error,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [7:0]              rsp_result,
  output logic                    rsp_error,
  output logic                    rsp_timeout,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  cmd_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [AW:0]   FULL   = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t        state_reg, state_next;
  logic [9:0]    mem [DEPTH];
  logic [9:0]    head;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [TW-1:0] timer_reg;
  logic          push, pop, cap_done, cap_timeout, timer_clr, timer_inc;

  // No full-bypass: a pop in the same cycle does not make room for a push.
  assign cmd_ready = (count_reg != FULL);
  assign cmd_count = count_reg;
  assign busy      = (state_reg != IDLE);
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {cmd_a, cmd_b, cmd_op};
  end

  always_comb begin
    state_next  = state_reg;
    pop         = 1'b0;
    cap_done    = 1'b0;
    cap_timeout = 1'b0;
    timer_clr   = 1'b0;
    timer_inc   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        timer_clr  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (alu_done) begin
          cap_done   = 1'b1;
          state_next = HOLD;
        end else if (timer_reg == T_LAST) begin
          cap_timeout = 1'b1;
          state_next  = HOLD;
        end else begin
          timer_inc = 1'b1;
        end
      end
      HOLD: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      timer_reg   <= '0;
      alu_A       <= '0;
      alu_B       <= '0;
      alu_opcode  <= '0;
      alu_start   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_reg <= state_next;
      alu_start <= pop;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop) begin
        rd_ptr_reg                  <= rd_ptr_reg + AW'(1);
        {alu_A, alu_B, alu_opcode}  <= head;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
      if (timer_clr)      timer_reg <= '0;
      else if (timer_inc) timer_reg <= timer_reg + TW'(1);
      if (cap_done) begin
        rsp_valid   <= 1'b1;
        rsp_result  <= alu_result;
        rsp_error   <= alu_error;
        rsp_timeout <= 1'b0;
      end else if (cap_timeout) begin
        rsp_valid   <= 1'b1;
        rsp_result  <= '0;
        rsp_error   <= 1'b0;
        rsp_timeout <= 1'b1;
      end else if (state_reg == HOLD && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: behavioural ALU, response scoreboard,
// directed scenarios and a randomized traffic run.
module tb_alu_cmd_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_a, cmd_b;
  logic [1:0] cmd_op;
  logic [3:0] alu_A, alu_B;
  logic [1:0] alu_opcode;
  logic       alu_start;
  logic [7:0] alu_result;
  logic       alu_done, alu_error;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_error, rsp_timeout, busy;
  logic [$clog2(DEPTH):0] cmd_count;

  logic       mute;
  int         passed = 0;
  int         total  = 0;
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  int         exp_rd = 0;
  int         got_rd = 0;
  int         start_cnt = 0;
  int         run = 0;
  int         max_run = 0;
  int         op_viol = 0;
  logic [9:0] op_lat = '0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_A(alu_A), .alu_B(alu_B), .alu_opcode(alu_opcode), .alu_start(alu_start),
    .alu_result(alu_result), .alu_done(alu_done), .alu_error(alu_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .busy(busy), .cmd_count(cmd_count)
  );

  // Behavioural ALU: samples start, raises done for one cycle on the following cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_done   <= 1'b0;
      alu_result <= '0;
      alu_error  <= 1'b0;
    end else begin
      alu_done <= alu_start && !mute;
      if (alu_start) begin
        alu_error <= 1'b0;
        case (alu_opcode)
          2'd0: alu_result <= 8'(alu_A) + 8'(alu_B);
          2'd1: alu_result <= 8'(alu_A) - 8'(alu_B);
          2'd2: alu_result <= 8'(alu_A) * 8'(alu_B);
          default: begin
            if (alu_B == 4'd0) begin
              alu_result <= 8'd0;
              alu_error  <= 1'b1;
            end else begin
              alu_result <= 8'(alu_A / alu_B);
            end
          end
        endcase
      end
    end
  end

  // Reference response {timeout, error, result} from the command fields alone.
  function automatic logic [9:0] ref_rsp(input int a, input int b, input int op, input bit to);
    int r;
    bit e;
    r = 0;
    e = 1'b0;
    if (to) return 10'h200;
    case (op)
      0: r = a + b;
      1: r = (a - b + 256) % 256;
      2: r = a * b;
      default: if (b == 0) e = 1'b1; else r = a / b;
    endcase
    return {1'b0, e, 8'(r)};
  endfunction

  // Observer: records accepted commands (as expectations), responses and start/operand behaviour.
  always @(negedge clk) begin
    if (!reset) begin
      if (cmd_valid && cmd_ready) exp_q.push_back(ref_rsp(int'(cmd_a), int'(cmd_b), int'(cmd_op), mute));
      if (rsp_valid && rsp_ready) got_q.push_back({rsp_timeout, rsp_error, rsp_result});
      if (alu_start) begin
        start_cnt++;
        run++;
        if (run > max_run) max_run = run;
        op_lat = {alu_A, alu_B, alu_opcode};
      end else begin
        run = 0;
        if (busy && !rsp_valid && {alu_A, alu_B, alu_opcode} !== op_lat) op_viol++;
      end
    end else begin
      run = 0;
    end
  end

  task automatic do_push(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_got(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (got_q.size() >= got_rd + n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    rsp_ready = 1'b0; mute = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({rsp_valid, rsp_result, rsp_error, rsp_timeout, alu_start, alu_A, alu_B, alu_opcode, busy} !== '0)
      $display("FAIL reset_outputs: got %h required 0",
               {rsp_valid, rsp_result, rsp_error, rsp_timeout, alu_start, alu_A, alu_B, alu_opcode, busy});
    else passed++;
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); else passed++;
    total++;
    if (cmd_count !== '0) $display("FAIL reset_cmd_count: got %0d required 0", cmd_count); else passed++;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int s0, lat;
    bit ok;
    rsp_ready = 1'b1;
    s0 = start_cnt;
    lat = -1;
    do_push(4'd7, 4'd9, 2'd0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i - 1;
        break;
      end
    end
    total++;
    if (lat !== 3) $display("FAIL basic_latency: got %0d required 3", lat); else passed++;
    total++;
    if ({rsp_timeout, rsp_error, rsp_result} !== 10'h010)
      $display("FAIL basic_rsp: got %h required 010", {rsp_timeout, rsp_error, rsp_result});
    else passed++;
    wait_got(1, 5, ok);
    total++;
    if (!ok) $display("FAIL basic_handshake: got no response required one");
    else begin
      passed++;
      total++;
      if (got_q[got_rd] !== exp_q[exp_rd])
        $display("FAIL basic_scoreboard: got %h required %h", got_q[got_rd], exp_q[exp_rd]);
      else passed++;
      got_rd++; exp_rd++;
    end
    total++;
    if (start_cnt - s0 !== 1) $display("FAIL basic_start_count: got %0d required 1", start_cnt - s0); else passed++;
    total++;
    if (max_run !== 1) $display("FAIL basic_start_width: got %0d required 1", max_run); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [9:0] want [3];
    logic [3:0] av [3];
    logic [3:0] bv [3];
    logic [1:0] ov [3];
    int s0;
    bit ok;
    want[0] = 10'h0FE; want[1] = 10'h0E1; want[2] = 10'h004;
    av[0] = 4'd3;  bv[0] = 4'd5;  ov[0] = 2'd1;
    av[1] = 4'd15; bv[1] = 4'd15; ov[1] = 2'd2;
    av[2] = 4'd9;  bv[2] = 4'd2;  ov[2] = 2'd3;
    s0 = start_cnt;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_a = av[i]; cmd_b = bv[i]; cmd_op = ov[i];
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    wait_got(3, 60, ok);
    total++;
    if (!ok) $display("FAIL b2b_drain: got %0d responses required 3", got_q.size() - got_rd);
    else begin
      passed++;
      for (int i = 0; i < 3; i++) begin
        total++;
        if (got_q[got_rd] !== want[i]) $display("FAIL b2b_rsp%0d: got %h required %h", i, got_q[got_rd], want[i]);
        else passed++;
        got_rd++; exp_rd++;
      end
    end
    total++;
    if (start_cnt - s0 !== 3) $display("FAIL b2b_start_count: got %0d required 3", start_cnt - s0); else passed++;
    total++;
    if (max_run !== 1) $display("FAIL b2b_start_width: got %0d required 1", max_run); else passed++;
    total++;
    if (op_viol !== 0) $display("FAIL b2b_operand_stable: got %0d changes required 0", op_viol); else passed++;
  endtask

  task automatic test_div_zero;
    bit ok;
    do_push(4'd6, 4'd0, 2'd3);
    wait_got(1, 20, ok);
    total++;
    if (!ok) $display("FAIL divzero_handshake: got no response required one");
    else begin
      passed++;
      total++;
      if (got_q[got_rd] !== 10'h100) $display("FAIL divzero_rsp: got %h required 100", got_q[got_rd]);
      else passed++;
      got_rd++; exp_rd++;
    end
  endtask

  task automatic test_backpressure;
    int acc, refused, n;
    bit ok;
    acc = 0; refused = 0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      cmd_valid = 1'b1;
      cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 2'($urandom);
      @(negedge clk);
      if (cmd_ready) acc++; else refused++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    total++;
    if (acc !== DEPTH + 1) $display("FAIL bp_accepted: got %0d required %0d", acc, DEPTH + 1); else passed++;
    total++;
    if (refused !== 1) $display("FAIL bp_refused: got %0d required 1", refused); else passed++;
    total++;
    if (cmd_ready !== 1'b0) $display("FAIL bp_cmd_ready: got %b required 0", cmd_ready); else passed++;
    total++;
    if (cmd_count !== DEPTH) $display("FAIL bp_cmd_count: got %0d required %0d", cmd_count, DEPTH); else passed++;
    total++;
    if (rsp_valid !== 1'b1) $display("FAIL bp_hold_valid: got %b required 1", rsp_valid); else passed++;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    n = exp_q.size() - exp_rd;
    wait_got(n, 100, ok);
    total++;
    if (!ok || n !== DEPTH + 1) $display("FAIL bp_drain: got %0d responses required %0d", got_q.size() - got_rd, DEPTH + 1);
    else passed++;
    while (got_rd < got_q.size() && exp_rd < exp_q.size()) begin
      total++;
      if (got_q[got_rd] !== exp_q[exp_rd]) $display("FAIL bp_rsp%0d: got %h required %h", got_rd, got_q[got_rd], exp_q[exp_rd]);
      else passed++;
      got_rd++; exp_rd++;
    end
  endtask

  task automatic test_timeout;
    int lat;
    bit ok;
    rsp_ready = 1'b1;
    mute = 1'b1;
    lat = -1;
    do_push(4'($urandom), 4'($urandom), 2'($urandom));
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i - 1;
        break;
      end
    end
    total++;
    if (lat !== TIMEOUT + 2) $display("FAIL timeout_latency: got %0d required %0d", lat, TIMEOUT + 2); else passed++;
    total++;
    if ({rsp_timeout, rsp_error, rsp_result} !== 10'h200)
      $display("FAIL timeout_rsp: got %h required 200", {rsp_timeout, rsp_error, rsp_result});
    else passed++;
    @(posedge clk); #1;
    mute = 1'b0;
    do_push(4'($urandom), 4'($urandom), 2'($urandom));
    wait_got(2, 30, ok);
    total++;
    if (!ok) $display("FAIL timeout_next: got %0d responses required 2", got_q.size() - got_rd);
    else begin
      passed++;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (got_q[got_rd] !== exp_q[exp_rd]) $display("FAIL timeout_rsp%0d: got %h required %h", i, got_q[got_rd], exp_q[exp_rd]);
        else passed++;
        got_rd++; exp_rd++;
      end
    end
  endtask

  task automatic test_reset_mid;
    int g;
    bit ok;
    rsp_ready = 1'b1;
    mute = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 2'($urandom);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, rsp_valid, cmd_count} !== {1'b1, 1'b0, 3'd2})
      $display("FAIL midreset_pre: got busy/valid/count %b/%b/%0d required 1/0/2", busy, rsp_valid, cmd_count);
    else passed++;
    g = got_q.size();
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    total++;
    if ({rsp_valid, rsp_result, rsp_error, rsp_timeout, alu_start, alu_A, alu_B, alu_opcode, busy, cmd_count} !== '0)
      $display("FAIL midreset_outputs: got %h required 0",
               {rsp_valid, rsp_result, rsp_error, rsp_timeout, alu_start, alu_A, alu_B, alu_opcode, busy, cmd_count});
    else passed++;
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL midreset_cmd_ready: got %b required 1", cmd_ready); else passed++;
    @(negedge clk);
    reset = 1'b0;
    mute = 1'b0;
    exp_rd = exp_q.size();
    repeat (30) @(posedge clk);
    #1;
    total++;
    if (got_q.size() !== g) $display("FAIL midreset_no_rsp: got %0d responses required 0", got_q.size() - g); else passed++;
    do_push(4'd5, 4'd3, 2'd1);
    wait_got(1, 20, ok);
    total++;
    if (!ok) $display("FAIL midreset_after: got no response required one");
    else begin
      passed++;
      total++;
      if (got_q[got_rd] !== 10'h002) $display("FAIL midreset_after_rsp: got %h required 002", got_q[got_rd]);
      else passed++;
      got_rd++; exp_rd++;
    end
  endtask

  task automatic test_random;
    int n;
    bit ok;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      cmd_valid = 1'($urandom);
      cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 2'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n = exp_q.size() - exp_rd;
    wait_got(n, 200, ok);
    total++;
    if (!ok) $display("FAIL random_drain: got %0d responses required %0d", got_q.size() - got_rd, n); else passed++;
    while (got_rd < got_q.size() && exp_rd < exp_q.size()) begin
      total++;
      if (got_q[got_rd] !== exp_q[exp_rd]) $display("FAIL random_rsp%0d: got %h required %h", got_rd, got_q[got_rd], exp_q[exp_rd]);
      else passed++;
      got_rd++; exp_rd++;
    end
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (got_q.size() - got_rd !== 0) $display("FAIL random_extra: got %0d extra responses required 0", got_q.size() - got_rd);
    else passed++;
    total++;
    if (op_viol !== 0 || max_run !== 1)
      $display("FAIL random_start_ops: got changes/width %0d/%0d required 0/1", op_viol, max_run);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
